// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: FSM state
// enumeration, default memory depth, header width constants.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CSUM state.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 64;
    localparam int DEFAULT_CNT_W       = 16;
    localparam int HDR_BYTES           = 2;

    typedef enum logic [2:0] {
        ST_HDR_HI = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        ST_CSUM   = 3'd6
`endif
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Groups the loader's byte-stream handshake, instruction-memory write bus
// and status signals.
//   master : the loader itself (accepts bytes, drives memory writes/status)
//   slave  : the byte source / memory / processor side
// Signals: byte_valid, byte_data[7:0], byte_ready, reload, imem_we,
//          imem_addr[31:0], imem_wdata[31:0], cpu_reset, done, err.
// ---------------------------------------------------------------------------
interface imem_loader_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    modport master (
        input  byte_valid, byte_data, reload,
        output byte_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, err
    );

    modport slave (
        output byte_valid, byte_data, reload,
        input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, err
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_loader_byte_packer
// Assembles four big-endian bytes into a 32-bit word. Only the first three
// bytes are stored; the fourth is merged combinationally so the complete
// word is visible in the same cycle the last byte is accepted.
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   clear_i      : discard any partial word
//   shift_i      : accept byte_i into the word
//   byte_i       : incoming byte
//   word_o       : {stored bytes, byte_i}, valid when wordReady_o = 1
//   wordReady_o  : this shift completes a word
// ---------------------------------------------------------------------------
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        wordReady_o
);

    logic [23:0] shift_q;
    logic [1:0]  byteIdx_q;

    // Byte index wraps 3 -> 0 naturally, so a new word starts automatically.
    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            shift_q   <= '0;
            byteIdx_q <= '0;
        end else if (shift_i) begin
            shift_q   <= {shift_q[15:0], byte_i};
            byteIdx_q <= byteIdx_q + 2'd1;
        end
    end

    assign word_o      = {shift_q, byte_i};
    assign wordReady_o = shift_i && (byteIdx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a byte stream (2-byte big-endian word count N, then N big-endian
// 32-bit words) and writes the words into instruction memory starting at
// address 0. Holds the processor in reset until a load completes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- a trailing byte must
// equal the XOR of all header and data bytes, else the load errors.
// Ports:
//   clk    : clock
//   reset  : synchronous active-low reset
//   bus    : imem_loader_if.master (byte handshake, memory write, status)
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus
);

    localparam logic [CNT_W-1:0] DEPTH_LIMIT = CNT_W'(DEPTH_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e LOAD_END_STATE = ST_CSUM;
`else
    localparam state_e LOAD_END_STATE = ST_DONE;
`endif

    state_e                 state_q, state_d;
    logic [7:0]             countHi_q, countHi_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       wordIdx_q, wordIdx_d;
    logic [CNT_W-1:0]       wordIdxInc;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [HDR_BYTES*8-1:0] hdrWord;
    logic [CNT_W-1:0]       hdrCount;
    logic                   byteReady;
    logic                   xfer;
    logic                   packClear;
    logic                   packShift;
    logic                   wordReady;
    logic [31:0]            packWord;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]             csum_q, csum_d;
`endif

    assign byteReady = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                       (state_q == ST_CSUM) ||
`endif
                       (state_q == ST_DATA);

    assign xfer       = bus.byte_valid && byteReady;
    assign hdrWord    = {countHi_q, bus.byte_data};
    assign hdrCount   = CNT_W'(hdrWord);
    assign wordIdxInc = wordIdx_q + CNT_W'(1);

    imem_loader_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (packClear),
        .shift_i     (packShift),
        .byte_i      (bus.byte_data),
        .word_o      (packWord),
        .wordReady_o (wordReady)
    );

    // Next-state logic. Address and data are captured on the transition
    // into WRITE so they are presented during WRITE and held afterwards.
    always_comb begin
        state_d   = state_q;
        countHi_d = countHi_q;
        count_d   = count_q;
        wordIdx_d = wordIdx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        packClear = 1'b0;
        packShift = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
        if (xfer && (state_q != ST_CSUM)) begin
            csum_d = csum_q ^ bus.byte_data;
        end
`endif

        case (state_q)
            ST_HDR_HI: begin
                if (xfer) begin
                    countHi_d = bus.byte_data;
                    state_d   = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (xfer) begin
                    count_d   = hdrCount;
                    wordIdx_d = '0;
                    packClear = 1'b1;
                    if (hdrCount == '0) begin
                        state_d = LOAD_END_STATE;
                    end else if (hdrCount > DEPTH_LIMIT) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    packShift = 1'b1;
                    if (wordReady) begin
                        addr_d  = 32'(wordIdx_q) << 2;
                        wdata_d = packWord;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                wordIdx_d = wordIdxInc;
                state_d   = (wordIdxInc == count_q) ? LOAD_END_STATE : ST_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) begin
                    state_d = (bus.byte_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (bus.reload) begin
                    state_d = ST_HDR_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            default: begin
                state_d = ST_HDR_HI;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_HDR_HI;
            countHi_q <= '0;
            count_q   <= '0;
            wordIdx_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            countHi_q <= countHi_d;
            count_q   <= count_d;
            wordIdx_q <= wordIdx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign bus.byte_ready = byteReady;
    assign bus.imem_we    = (state_q == ST_WRITE);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_reset  = (state_q != ST_DONE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.err        = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. A stream-level model derives the
// expected write strobes, addresses, data and status from the bytes that
// are accepted; a compare process checks the DUT against it every cycle,
// and each scenario pins the model with hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset;

    imem_loader_if bus();

    imem_loader #(
        .DEPTH_WORDS (DEPTH),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int fails    = 0;

    logic [7:0]  stimQ[$];
    logic [31:0] logAddr[$];
    logic [31:0] logData[$];
    logic [7:0]  tbXor;

    typedef enum int {M_LOAD, M_CSUM, M_DONE, M_ERR} mstat_e;

    mstat_e      mStatus;
    logic [7:0]  mBytes[$];
    int          mN;
    int          mWritten;
    bit          mWePend;
    logic [31:0] mAddr;
    logic [31:0] mData;
    bit          modelValid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mstat_e endOfLoad();
`ifdef IMEM_LOADER_CHECKSUM_EN
        return M_CSUM;
`else
        return M_DONE;
`endif
    endfunction

    function automatic bit modelReady();
        return ((mStatus == M_LOAD) || (mStatus == M_CSUM)) && !mWePend;
    endfunction

    function automatic void modelRestart();
        mStatus  = M_LOAD;
        mBytes.delete();
        mN       = 0;
        mWritten = 0;
        mWePend  = 1'b0;
    endfunction

    // Stream-level interpretation of one accepted byte.
    function automatic void modelAccept(input logic [7:0] b);
        logic [7:0] x;
        int n;
        if (mStatus == M_CSUM) begin
            x = 8'h00;
            foreach (mBytes[i]) x = x ^ mBytes[i];
            mStatus = (b == x) ? M_DONE : M_ERR;
        end else begin
            mBytes.push_back(b);
            n = mBytes.size();
            if (n == 2) begin
                mN = {16'd0, mBytes[0], mBytes[1]};
                if (mN == 0) mStatus = endOfLoad();
                else if (mN > DEPTH) mStatus = M_ERR;
            end else if ((n > 2) && (((n - 2) % 4) == 0)) begin
                mWePend = 1'b1;
                mAddr   = 32'(((n - 2) / 4 - 1) * 4);
                mData   = {mBytes[n-4], mBytes[n-3], mBytes[n-2], mBytes[n-1]};
                mWritten++;
            end
        end
    endfunction

    // Compare process: outputs are checked at the falling edge, then the
    // model advances using the inputs that the next rising edge will see.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("imem_we",    32'(bus.imem_we),    32'(mWePend));
            checkOutput("byte_ready", 32'(bus.byte_ready), 32'(modelReady()));
            checkOutput("done",       32'(bus.done),       32'(mStatus == M_DONE));
            checkOutput("err",        32'(bus.err),        32'(mStatus == M_ERR));
            checkOutput("cpu_reset",  32'(bus.cpu_reset),  32'(mStatus != M_DONE));
            checkOutput("imem_addr",  bus.imem_addr,       mAddr);
            checkOutput("imem_wdata", bus.imem_wdata,      mData);
            if (bus.imem_we === 1'b1) begin
                logAddr.push_back(bus.imem_addr);
                logData.push_back(bus.imem_wdata);
            end
        end
        if (reset === 1'b0) begin
            modelRestart();
            mAddr      = 32'h0;
            mData      = 32'h0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (mWePend) begin
                mWePend = 1'b0;
                if (mWritten == mN) mStatus = endOfLoad();
            end else if (((mStatus == M_DONE) || (mStatus == M_ERR)) && (bus.reload === 1'b1)) begin
                modelRestart();
            end else if (modelReady() && (bus.byte_valid === 1'b1)) begin
                modelAccept(bus.byte_data);
            end
        end
    end

    // Sends every byte in stimQ; optionally drops byte_valid between bytes.
    task automatic applyStimulus(input bit toggle);
        bit acc;
        int budget;
        @(posedge clk); #1;
        foreach (stimQ[k]) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = stimQ[k];
            acc    = 1'b0;
            budget = 0;
            while (!acc && budget < 50) begin
                @(negedge clk);
                acc = bus.byte_ready;
                @(posedge clk); #1;
                budget++;
            end
            if (!acc) begin
                testsRun++;
                fails++;
                $display("[TB] FAIL byte_accept_timeout: got no byte_ready expected byte_ready=1 for byte %h", stimQ[k]);
            end
            tbXor = tbXor ^ stimQ[k];
            if (toggle) begin
                bus.byte_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic sendChecksum();
        stimQ = '{tbXor};
        applyStimulus(1'b0);
    endtask

    task automatic startLoad();
        tbXor = 8'h00;
        logAddr.delete();
        logData.delete();
    endtask

    task automatic waitFinish();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done || bus.err;
        end
        if (!seen) begin
            testsRun++;
            fails++;
            $display("[TB] FAIL finish_timeout: got done=0 err=0 expected done or err");
        end
    endtask

    task automatic pulseReload();
        @(posedge clk); #1;
        bus.reload = 1'b1;
        @(posedge clk); #1;
        bus.reload = 1'b0;
    endtask

    task automatic loadExampleStream(input bit toggle);
        startLoad();
        stimQ = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
        applyStimulus(toggle);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendChecksum();
`endif
        waitFinish();
    endtask

    task automatic checkExampleWrites(input string tag);
        checkOutput({tag, "_nwrites"}, 32'(logAddr.size()), 32'd2);
        if (logAddr.size() == 2) begin
            checkOutput({tag, "_addr0"}, logAddr[0], 32'h0000_0000);
            checkOutput({tag, "_data0"}, logData[0], 32'h2008_0005);
            checkOutput({tag, "_addr1"}, logAddr[1], 32'h0000_0004);
            checkOutput({tag, "_data1"}, logData[1], 32'h8C09_0000);
        end
        checkOutput({tag, "_done"},      32'(bus.done),      32'd1);
        checkOutput({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        reset          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.reload     = 1'b0;
        tbXor          = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Reset values
        @(negedge clk);
        checkOutput("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
        checkOutput("rst_imem_we",    32'(bus.imem_we),    32'd0);
        checkOutput("rst_imem_addr",  bus.imem_addr,       32'h0);
        checkOutput("rst_imem_wdata", bus.imem_wdata,      32'h0);
        checkOutput("rst_cpu_reset",  32'(bus.cpu_reset),  32'd1);
        checkOutput("rst_done",       32'(bus.done),       32'd0);
        checkOutput("rst_err",        32'(bus.err),        32'd0);

        $display("[TB] example stream, continuous valid");
        loadExampleStream(1'b0);
        checkExampleWrites("cont");

        $display("[TB] example stream, toggling valid");
        pulseReload();
        loadExampleStream(1'b1);
        checkExampleWrites("toggle");

        $display("[TB] oversize header");
        pulseReload();
        startLoad();
        stimQ = '{8'h00, 8'h41};
        applyStimulus(1'b0);
        waitFinish();
        checkOutput("ovf_err",       32'(bus.err),         32'd1);
        checkOutput("ovf_done",      32'(bus.done),        32'd0);
        checkOutput("ovf_cpu_reset", 32'(bus.cpu_reset),   32'd1);
        checkOutput("ovf_nwrites",   32'(logAddr.size()),  32'd0);

        $display("[TB] zero-length load");
        pulseReload();
        startLoad();
        stimQ = '{8'h00, 8'h00};
        applyStimulus(1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        stimQ = '{8'h00};
        applyStimulus(1'b0);
`endif
        waitFinish();
        checkOutput("zero_done",    32'(bus.done),        32'd1);
        checkOutput("zero_nwrites", 32'(logAddr.size()),  32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        pulseReload();
        startLoad();
        stimQ = '{8'h00, 8'h00, 8'h01};
        applyStimulus(1'b0);
        waitFinish();
        checkOutput("csum_bad_err", 32'(bus.err), 32'd1);
`endif

        $display("[TB] reset in the middle of a word");
        pulseReload();
        startLoad();
        stimQ = '{8'h00, 8'h01, 8'hAB, 8'hCD};
        applyStimulus(1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        loadExampleStream(1'b0);
        checkExampleWrites("midrst");

        $display("[TB] bytes offered in DONE, then reload with ignored mid-load reload");
        @(posedge clk); #1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1 bus.byte_valid = 1'b0;
        pulseReload();
        startLoad();
        stimQ = '{8'h00, 8'h01};
        applyStimulus(1'b0);
        pulseReload();
        stimQ = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        applyStimulus(1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendChecksum();
`endif
        waitFinish();
        checkOutput("reload_nwrites", 32'(logAddr.size()), 32'd1);
        if (logAddr.size() == 1) begin
            checkOutput("reload_addr0", logAddr[0], 32'h0000_0000);
            checkOutput("reload_data0", logData[0], 32'hFFFF_FFFF);
        end
        checkOutput("reload_done",      32'(bus.done),      32'd1);
        checkOutput("reload_cpu_reset", 32'(bus.cpu_reset), 32'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, fails);
        $finish;
    end

endmodule
